// File: rtl/ber_mon_pkg.sv
// Shared types and default constants for the bit-error-rate monitor.
package ber_mon_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_e;

  localparam int DEF_MAX_DELAY = 64;
  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_SYNC_LEN  = 32;
  localparam int DEF_LOSS_ERR  = 256;

  localparam int DEF_DELAY_W = $clog2(DEF_MAX_DELAY);
  localparam int DEF_CNT_W   = $clog2(DEF_WINDOW + 1);
  localparam int TOTAL_W     = 32;

endpackage

// File: rtl/ber_monitor_if.sv
// Bit stream inputs and readout outputs of the BER monitor, bundled as one interface.
interface ber_monitor_if
  import ber_mon_pkg::*;
#(
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int CNT_W   = DEF_CNT_W
) ();

  logic               bit_valid;
  logic               rx_bit;
  logic               ref_bit;
  logic               locked;
  logic [DELAY_W-1:0] lock_delay;
  logic [CNT_W-1:0]   err_count;
  logic               window_done;
  logic [TOTAL_W-1:0] total_err;

  modport master (
    output bit_valid, rx_bit, ref_bit,
    input  locked, lock_delay, err_count, window_done, total_err
  );

  modport slave (
    input  bit_valid, rx_bit, ref_bit,
    output locked, lock_delay, err_count, window_done, total_err
  );

endinterface

// File: rtl/ref_delay_line.sv
// Reference bit history with a tap mux; tap 0 passes the live bit, tap d the bit from d strobes earlier.
module ref_delay_line #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [IDX_W-1:0] tap,
  output logic             bit_out
);

  // Tap DEPTH-1 reads the oldest stored bit, so only DEPTH-1 stages are kept.
  logic [DEPTH-2:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (shift_en) begin
      shreg_d = (shreg_q << 1) | {{(DEPTH-2){1'b0}}, bit_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    bit_out = bit_in;
    if (tap != '0) begin
      bit_out = shreg_q[tap - IDX_W'(1)];
    end
  end

endmodule

// File: rtl/ber_monitor.sv
// BER monitor: searches for the decoder delay, then counts mismatches per window.
// Optional feature macro BER_MON_TOTAL_EN enables the saturating cumulative total_err counter.
module ber_monitor
  import ber_mon_pkg::*;
#(
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int SYNC_LEN  = DEF_SYNC_LEN,
  parameter int LOSS_ERR  = DEF_LOSS_ERR
) (
  input logic          sys_clk,
  input logic          reset,
  ber_monitor_if.slave mon
);

  localparam int DELAY_W = $clog2(MAX_DELAY);
  localparam int CNT_W   = $clog2(WINDOW + 1);
  localparam int MATCH_W = $clog2(SYNC_LEN + 1);

  ber_state_e         state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               window_done_q, window_done_d;
  logic [CNT_W-1:0]   win_err_inc;
  logic               ref_dly;
  logic               mismatch;

  ref_delay_line #(
    .DEPTH (MAX_DELAY),
    .IDX_W (DELAY_W)
  ) u_ref_delay_line (
    .clk      (sys_clk),
    .reset    (reset),
    .shift_en (mon.bit_valid),
    .bit_in   (mon.ref_bit),
    .tap      (delay_q),
    .bit_out  (ref_dly)
  );

  assign mismatch    = mon.rx_bit ^ ref_dly;
  assign win_err_inc = win_err_q + CNT_W'(mismatch);

  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    match_d       = match_q;
    bit_cnt_d     = bit_cnt_q;
    win_err_d     = win_err_q;
    err_count_d   = err_count_q;
    window_done_d = 1'b0;
    if (mon.bit_valid) begin
      case (state_q)
        SEARCH: begin
          if (mismatch) begin
            match_d = '0;
            delay_d = (delay_q == DELAY_W'(MAX_DELAY - 1)) ? '0 : delay_q + DELAY_W'(1);
          end else if (match_q == MATCH_W'(SYNC_LEN - 1)) begin
            state_d   = LOCKED;
            match_d   = '0;
            bit_cnt_d = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // The window-closing bit is included in the reported count.
          if (bit_cnt_q == CNT_W'(WINDOW - 1)) begin
            err_count_d   = win_err_inc;
            window_done_d = 1'b1;
            bit_cnt_d     = '0;
            win_err_d     = '0;
            if (win_err_inc > CNT_W'(LOSS_ERR)) begin
              state_d = SEARCH;
              match_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            win_err_d = win_err_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      delay_q       <= '0;
      match_q       <= '0;
      bit_cnt_q     <= '0;
      win_err_q     <= '0;
      err_count_q   <= '0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      match_q       <= match_d;
      bit_cnt_q     <= bit_cnt_d;
      win_err_q     <= win_err_d;
      err_count_q   <= err_count_d;
      window_done_q <= window_done_d;
    end
  end

  assign mon.locked      = (state_q == LOCKED);
  assign mon.lock_delay  = delay_q;
  assign mon.err_count   = err_count_q;
  assign mon.window_done = window_done_q;

`ifdef BER_MON_TOTAL_EN
  logic [TOTAL_W-1:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (mon.bit_valid && (state_q == LOCKED) && mismatch && (total_q != '1)) begin
      total_d = total_q + TOTAL_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign mon.total_err = total_q;
`else
  assign mon.total_err = '0;
`endif

endmodule

// File: tb/tb_ber_monitor.sv
// Self-checking bench for ber_monitor: directed scenarios plus a window scoreboard and a cycle model.
module tb_ber_monitor;
  import ber_mon_pkg::*;

  localparam int MAX_DELAY = DEF_MAX_DELAY;
  localparam int WINDOW    = DEF_WINDOW;
  localparam int SYNC_LEN  = DEF_SYNC_LEN;
  localparam int LOSS_ERR  = DEF_LOSS_ERR;
  localparam int DW        = $clog2(MAX_DELAY);
  localparam int CW        = $clog2(WINDOW + 1);

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  ber_monitor_if #(.DELAY_W(DW), .CNT_W(CW)) bus ();

  ber_monitor #(
    .MAX_DELAY (MAX_DELAY),
    .WINDOW    (WINDOW),
    .SYNC_LEN  (SYNC_LEN),
    .LOSS_ERR  (LOSS_ERR)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .mon     (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the whole reference history is kept, indexed by strobe number.
  typedef struct {
    int err;
    bit locked;
  } win_t;
  win_t win_q[$];

  bit          ref_hist[$];
  bit          m_locked;
  int          m_delay, m_match, m_bits, m_errs, m_err_count;
  bit          m_wd;
  logic [31:0] m_total;

  bit          vis_locked, vis_wd;
  int          vis_delay, vis_err;
  logic [31:0] vis_total = '0;
  bit          mon_en    = 1'b0;
  bit          track_bad = 1'b0;
  bit          saw_wrap  = 1'b0;
  logic [DW-1:0] prev_delay = '0;

  bit       stim_ref[$];
  logic [6:0] lfsr;
  int       stim_cnt = 0;

  function automatic void model_reset();
    ref_hist.delete();
    m_locked = 1'b0;
    m_delay = 0; m_match = 0; m_bits = 0; m_errs = 0; m_err_count = 0;
    m_wd = 1'b0;
    m_total = '0;
  endfunction

  function automatic void model_strobe(input bit rx, input bit rf);
    bit   dref, mis;
    win_t w;
    int   sz = ref_hist.size();
    if (m_delay == 0)       dref = rf;
    else if (sz >= m_delay) dref = ref_hist[sz - m_delay];
    else                    dref = 1'b0;
    ref_hist.push_back(rf);
    mis = rx ^ dref;
    if (!m_locked) begin
      if (mis) begin
        m_match = 0;
        m_delay = (m_delay + 1) % MAX_DELAY;
      end else begin
        m_match++;
        if (m_match == SYNC_LEN) begin
          m_locked = 1'b1; m_match = 0; m_bits = 0; m_errs = 0;
        end
      end
    end else begin
`ifdef BER_MON_TOTAL_EN
      if (mis && m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
`endif
      m_bits++;
      m_errs += int'(mis);
      if (m_bits == WINDOW) begin
        m_err_count = m_errs;
        m_wd = 1'b1;
        w.err = m_errs;
        w.locked = (m_errs <= LOSS_ERR);
        win_q.push_back(w);
        if (m_errs > LOSS_ERR) begin
          m_locked = 1'b0; m_match = 0;
        end
        m_bits = 0; m_errs = 0;
      end
    end
  endfunction

  always @(posedge sys_clk) begin
    vis_locked = m_locked;
    vis_delay  = m_delay;
    vis_wd     = m_wd;
    vis_err    = m_err_count;
    vis_total  = m_total;
  end

  // Cycle-by-cycle comparison against the model, and window scoreboard popping.
  always @(negedge sys_clk) begin
    win_t e;
    if (mon_en) begin
      if (!track_bad) begin
        tests_run++;
        assert (bus.locked === vis_locked && bus.lock_delay === DW'(vis_delay) &&
                bus.window_done === vis_wd && bus.err_count === CW'(vis_err) &&
                bus.total_err === vis_total)
        else begin
          tests_failed++;
          track_bad = 1'b1;
          $error("[TB] FAIL track: observed locked=%0b delay=%0d wd=%0b err=%0d total=%0d expected locked=%0b delay=%0d wd=%0b err=%0d total=%0d",
                 bus.locked, bus.lock_delay, bus.window_done, bus.err_count, bus.total_err,
                 vis_locked, vis_delay, vis_wd, vis_err, vis_total);
        end
      end
      if (bus.window_done === 1'b1) begin
        tests_run++;
        if (win_q.size() == 0) begin
          tests_failed++;
          $error("[TB] FAIL window_unexpected: observed window_done=1 expected 0");
        end else begin
          e = win_q.pop_front();
          assert (bus.err_count === CW'(e.err) && bus.locked === e.locked)
          else begin
            tests_failed++;
            $error("[TB] FAIL window_score: observed err=%0d locked=%0b expected err=%0d locked=%0b",
                   bus.err_count, bus.locked, e.err, e.locked);
          end
        end
      end
      if (prev_delay == DW'(MAX_DELAY - 1) && bus.lock_delay == '0 && bus.locked === 1'b0)
        saw_wrap = 1'b1;
      prev_delay = bus.lock_delay;
    end
  end

  task automatic apply_stimulus(input bit valid, input bit rx, input bit rf, input bit rst);
    @(posedge sys_clk);
    #1;
    reset         = rst;
    bus.bit_valid = valid;
    bus.rx_bit    = rx;
    bus.ref_bit   = rf;
    if (rst) begin
      model_reset();
    end else begin
      m_wd = 1'b0;
      if (valid) model_strobe(rx, rf);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stim_reset();
    stim_ref.delete();
    lfsr = 7'h7F;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    stim_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: clean, 1: flip in-window positions 50,150..950, 2: invert while locked
  task automatic run_bits(input int count, input int d, input int mode);
    bit rf, rx;
    int n;
    for (int i = 0; i < count; i++) begin
      stim_cnt++;
      if (stim_cnt % 37 == 36)
        apply_stimulus(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      rf   = lfsr[6];
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      stim_ref.push_back(rf);
      n  = stim_ref.size() - 1;
      rx = (n >= d) ? stim_ref[n - d] : 1'b0;
      if (mode == 1 && m_locked && (m_bits % 100 == 50) && m_bits < 1000) rx = ~rx;
      if (mode == 2 && m_locked) rx = ~rx;
      apply_stimulus(1'b1, rx, rf, 1'b0);
    end
  endtask

  task automatic run_until_locked(input int d, input int budget);
    for (int i = 0; i < budget && !m_locked; i++) run_bits(1, d, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    bus.rx_bit    = 1'b0;
    bus.ref_bit   = 1'b0;
    model_reset();
    stim_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("rst_locked", 32'(bus.locked), 0);
    check_output("rst_delay", 32'(bus.lock_delay), 0);
    check_output("rst_err", 32'(bus.err_count), 0);
    check_output("rst_wd", 32'(bus.window_done), 0);
    check_output("rst_total", bus.total_err, 0);

    // Delay 5, clean stream: lock at 5 and two error-free windows
    run_until_locked(5, 3000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("d5_locked", 32'(bus.locked), 1);
    check_output("d5_delay", 32'(bus.lock_delay), 5);
    run_bits(2 * WINDOW, 5, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("d5_clean_err", 32'(bus.err_count), 0);
    check_output("d5_clean_locked", 32'(bus.locked), 1);

    // Ten flipped bits per window over three windows
    run_bits(3 * WINDOW, 5, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("flip_err", 32'(bus.err_count), 10);
    check_output("flip_locked", 32'(bus.locked), 1);
`ifdef BER_MON_TOTAL_EN
    check_output("flip_total", bus.total_err, 30);
`else
    check_output("flip_total", bus.total_err, 0);
`endif

    // Reset mid-window discards the partial window
    run_bits(300, 5, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    stim_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("mid_rst_locked", 32'(bus.locked), 0);
    check_output("mid_rst_delay", 32'(bus.lock_delay), 0);
    check_output("mid_rst_err", 32'(bus.err_count), 0);
    check_output("mid_rst_wd", 32'(bus.window_done), 0);
    check_output("mid_rst_total", bus.total_err, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Inverted window drops lock in the window_done cycle; search resumes at 5
    run_until_locked(5, 3000);
    run_bits(WINDOW, 5, 2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("inv_wd", 32'(bus.window_done), 1);
    check_output("inv_err", 32'(bus.err_count), WINDOW);
    check_output("inv_locked", 32'(bus.locked), 0);
    check_output("inv_delay", 32'(bus.lock_delay), 5);
    run_bits(SYNC_LEN, 5, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("relock_locked", 32'(bus.locked), 1);
    check_output("relock_delay", 32'(bus.lock_delay), 5);
    check_output("relock_err_held", 32'(bus.err_count), WINDOW);

    // Largest candidate delay
    do_reset();
    run_until_locked(MAX_DELAY - 1, 6000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("d63_locked", 32'(bus.locked), 1);
    check_output("d63_delay", 32'(bus.lock_delay), MAX_DELAY - 1);

    // One beyond the delay line: never locks, candidate wraps
    do_reset();
    saw_wrap = 1'b0;
    run_bits(1500, MAX_DELAY, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("d64_locked", 32'(bus.locked), 0);
    check_output("d64_wrap", 32'(saw_wrap), 1);

    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("win_queue_empty", 32'(win_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ber_monitor.md
# ber_monitor

Bit-error-rate monitor sitting directly downstream of the transmitter/receiver chain top. Consumes the Viterbi decoder output bit and the reference M-sequence bit, and aligns them by searching for the unknown pipeline delay. Once locked, counts mismatches over fixed windows and reports error counts and lock status to display/readout logic.

## Interface
Parameters:
- MAX_DELAY, 64: reference delay-line depth; candidate delays 0..MAX_DELAY-1.
- WINDOW, 1024: decoded bits per measurement window.
- SYNC_LEN, 32: consecutive matches needed to declare lock.
- LOSS_ERR, 256: window error count strictly above this drops lock.

Ports:
- sys_clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- bit_valid, in, 1: one-cycle strobe per decoded bit (sys_clk domain).
- rx_bit, in, 1: decoder output bit, sampled when bit_valid=1.
- ref_bit, in, 1: reference M-sequence bit, sampled when bit_valid=1.
- locked, out, 1: alignment found.
- lock_delay, out, $clog2(MAX_DELAY): current candidate/locked delay.
- err_count, out, $clog2(WINDOW+1): errors in last completed window.
- window_done, out, 1: one-cycle pulse when err_count updates.
- total_err, out, 32: saturating cumulative error count (see Configuration).

## Operation
- Delay line: on bit_valid, shift ref_bit into shreg (shreg[0] newest). Delayed reference for delay d = ref_bit when d=0, else pre-shift shreg[d-1]; i.e. ref bit from d strobes earlier.
- Per strobe: mismatch = rx_bit XOR delayed reference. No action when bit_valid=0.
- FSM states SEARCH, LOCKED.
- SEARCH: match counter counts consecutive matches. Mismatch -> match counter 0, d <= d+1 (MAX_DELAY-1 wraps to 0). Match counter reaching SYNC_LEN -> LOCKED, bit/error counters cleared.
- LOCKED: bit counter +1 per strobe, error counter +1 per mismatch. At WINDOW-th bit: err_count <= window errors including current bit; window_done pulses; counters restart at 0. If that count > LOSS_ERR -> SEARCH, d unchanged, match counter 0; else stay LOCKED.
- err_count holds its value across SEARCH; it is not cleared on lock loss.
- Counters never overflow: window error count ≤ WINDOW by construction.

## Timing
- Reset values: locked=0, lock_delay=0, err_count=0, window_done=0, total_err=0, shreg all 0, FSM SEARCH, all counters 0.
- All outputs registered. locked rises the cycle after the strobe completing the SYNC_LEN-th match.
- window_done and err_count update the cycle after the WINDOW-th locked strobe. locked falls in that same cycle when loss applies.
- lock_delay changes the cycle after a SEARCH mismatch strobe.
- Back-to-back strobes (bit_valid held high) fully supported; one bit per cycle.
- Reset mid-window or mid-search: everything returns to reset values the next cycle; partial window discarded, no window_done.

## Configuration
- BER_MON_TOTAL_EN defined: 32-bit total_err accumulates every LOCKED-state mismatch, saturates at 0xFFFFFFFF, and is cleared only by reset.
- Not defined: total_err tied to 0; accumulator logic absent.

## Structure
- Package ber_mon_pkg: FSM state enum (SEARCH, LOCKED), default parameter constants, width helper constants.
- One sub-module ref_delay_line: shift register plus tap mux (inputs shift enable, bit, tap index; output delayed bit). FSM and counters stay in ber_monitor.

## Test plan
- rx = ref (127-bit M-sequence) delayed 5 strobes, no errors -> lock_delay=5, locked=1, every window err_count=0.
- Delay 5, flip one rx bit every 100 strobes -> err_count 10 or 11 per 1024-bit window, locked stays 1.
- Once locked, invert rx for a full window -> err_count > 256, window_done pulses, locked=0 next cycle, search resumes from lock_delay=5.
- Delay 63 -> locks with lock_delay=63. Delay 64 -> never locks, lock_delay wraps 63->0.
- Assert reset for one cycle mid-window after lock -> next cycle locked=0, lock_delay=0, err_count=0, no window_done.
- With BER_MON_TOTAL_EN, three windows of 10 errors -> total_err=30. Without the macro -> total_err=0 throughout.
